// File: rtl/set_pkg.sv
// Shared types and constants for the hash-set command front-end.
// Imported by the sequencer top level.
package set_pkg;

  localparam int SET_DATA_W    = 8;
  localparam int SET_MAX_PROBE = 16;

  typedef enum logic {
    OP_FIND = 1'b0,
    OP_ADD  = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } seq_state_e;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with an occupancy counter.
// Buffers {op, key} commands ahead of the sequencer FSM.
module cmd_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == OCC_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: storage is not reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + OCC_W'(1);
        2'b01:   count <= count - OCC_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/set_cmd_sequencer.sv
// Command front-end for the hash set: queues find/add requests, issues them one
// at a time with a watchdog, and returns results with hit/miss/timeout statistics.
module set_cmd_sequencer
  import set_pkg::*;
#(
  parameter int DATA_W     = SET_DATA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 20,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_op,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_found,
  output logic              resp_timeout,
  output logic              set_find,
  output logic              set_add,
  output logic [DATA_W-1:0] set_x,
  input  logic              set_rdy,
  input  logic              set_found,
  output logic              busy,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic [CNT_W-1:0]  tmo_cnt
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  seq_state_e        state;
  op_e               op_q;
  logic [DATA_W-1:0] data_q;
  logic [WD_W-1:0]   wd;
  logic [DATA_W:0]   fifo_rd;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;

  assign pop = (state == IDLE) && !fifo_empty && set_rdy;

  cmd_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (cmd_valid),
    .wr_data ({cmd_op, cmd_data}),
    .pop     (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign cmd_ready = !fifo_full;
  assign busy      = (state != IDLE) || !fifo_empty;
  // The key register feeds the set directly, so set_x stays put from ISSUE through WAIT.
  assign set_x     = data_q;
  assign resp_data = data_q;
  assign resp_op   = op_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      op_q         <= OP_FIND;
      data_q       <= '0;
      wd           <= '0;
      set_find     <= 1'b0;
      set_add      <= 1'b0;
      resp_valid   <= 1'b0;
      resp_found   <= 1'b0;
      resp_timeout <= 1'b0;
      hit_cnt      <= '0;
      miss_cnt     <= '0;
      tmo_cnt      <= '0;
    end else begin
      set_find <= 1'b0;
      set_add  <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            op_q     <= op_e'(fifo_rd[DATA_W]);
            data_q   <= fifo_rd[DATA_W-1:0];
            set_find <= !fifo_rd[DATA_W];
            set_add  <= fifo_rd[DATA_W];
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          wd    <= '0;
          state <= WAIT;
        end
        WAIT: begin
          wd <= wd + WD_W'(1);
          if (set_rdy) begin
            resp_found   <= set_found;
            resp_timeout <= 1'b0;
            resp_valid   <= 1'b1;
            state        <= RESP;
          end else if (wd == WD_W'(TIMEOUT - 1)) begin
            resp_found   <= 1'b0;
            resp_timeout <= 1'b1;
            resp_valid   <= 1'b1;
            state        <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
            // Counters saturate at all-ones rather than wrapping.
            if (resp_timeout) begin
              if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + CNT_W'(1);
            end else if (resp_found) begin
              if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
            end else begin
              if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_set_cmd_sequencer.sv
// Directed testbench for set_cmd_sequencer: the bench plays the hash set by hand
// and checks strobes, key stability, responses, FIFO back-pressure and counters.
module tb_set_cmd_sequencer;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 20;
  localparam int CNT_W      = 16;
  localparam int LIMIT      = 10;

  logic              clk;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_op;
  logic [DATA_W-1:0] resp_data;
  logic              resp_found;
  logic              resp_timeout;
  logic              set_find;
  logic              set_add;
  logic [DATA_W-1:0] set_x;
  logic              set_rdy;
  logic              set_found;
  logic              busy;
  logic [CNT_W-1:0]  hit_cnt;
  logic [CNT_W-1:0]  miss_cnt;
  logic [CNT_W-1:0]  tmo_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  set_cmd_sequencer #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT    (TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_op      (resp_op),
    .resp_data    (resp_data),
    .resp_found   (resp_found),
    .resp_timeout (resp_timeout),
    .set_find     (set_find),
    .set_add      (set_add),
    .set_x        (set_x),
    .set_rdy      (set_rdy),
    .set_found    (set_found),
    .busy         (busy),
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt),
    .tmo_cnt      (tmo_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled just after the falling edge.
  task automatic tick;
    @(negedge clk);
  endtask

  task automatic push(input logic op, input logic [DATA_W-1:0] key);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = key;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_strobe(output int n);
    n = 0;
    do begin tick(); n++; end while (!(set_find || set_add) && n < LIMIT);
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    do begin tick(); n++; end while (!resp_valid && n < LIMIT);
  endtask

  task automatic test_reset;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_data = '0;
    resp_ready = 1'b1; set_rdy = 1'b1; set_found = 1'b0;
    tick(); tick();
    reset = 1'b0;
    n_checks++;
    if ({set_find, set_add, set_x, resp_valid, resp_op, resp_data, resp_found, resp_timeout,
         busy, hit_cnt, miss_cnt, tmo_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got strobes=%b%b x=%h rv=%b busy=%b cnt=%h/%h/%h, want all 0",
               set_find, set_add, set_x, resp_valid, busy, hit_cnt, miss_cnt, tmo_cnt);
    end
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_add_single;
    set_rdy = 1'b1; set_found = 1'b1;
    push(1'b1, 8'h25);
    n_checks++;
    if (busy !== 1'b1 || set_add !== 1'b0) begin
      n_fail++; $display("FAIL add_queued: got busy=%b add=%b want busy=1 add=0", busy, set_add);
    end
    tick();  // pop -> ISSUE
    n_checks++;
    if ({set_find, set_add, set_x} !== {1'b0, 1'b1, 8'h25}) begin
      n_fail++; $display("FAIL add_issue: got find=%b add=%b x=%h want 0 1 25", set_find, set_add, set_x);
    end
    tick();  // ISSUE -> WAIT
    n_checks++;
    if ({set_find, set_add, set_x, resp_valid} !== {1'b0, 1'b0, 8'h25, 1'b0}) begin
      n_fail++; $display("FAIL add_pulse_width: got find=%b add=%b x=%h rv=%b want 0 0 25 0",
                         set_find, set_add, set_x, resp_valid);
    end
    tick();  // one-cycle completion -> RESP
    n_checks++;
    if ({resp_valid, resp_op, resp_data, resp_found, resp_timeout} !== {1'b1, 1'b1, 8'h25, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL add_resp: got v=%b op=%b d=%h f=%b t=%b want 1 1 25 1 0",
                         resp_valid, resp_op, resp_data, resp_found, resp_timeout);
    end
    tick();  // handshake
    n_checks++;
    if ({resp_valid, busy, hit_cnt, miss_cnt, tmo_cnt} !== {1'b0, 1'b0, 16'd1, 16'd0, 16'd0}) begin
      n_fail++; $display("FAIL add_counters: got rv=%b busy=%b hit=%0d miss=%0d tmo=%0d want 0 0 1 0 0",
                         resp_valid, busy, hit_cnt, miss_cnt, tmo_cnt);
    end
  endtask

  task automatic test_find_probes;
    set_rdy = 1'b1; set_found = 1'b1;
    push(1'b0, 8'h35);
    tick();  // ISSUE
    n_checks++;
    if ({set_find, set_add, set_x} !== {1'b1, 1'b0, 8'h35}) begin
      n_fail++; $display("FAIL find_issue: got find=%b add=%b x=%h want 1 0 35", set_find, set_add, set_x);
    end
    set_rdy = 1'b0;  // set probing; set_found is don't-care and held high
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if ({set_find, set_add, set_x, resp_valid} !== {1'b0, 1'b0, 8'h35, 1'b0}) begin
        n_fail++; $display("FAIL find_wait_%0d: got find=%b add=%b x=%h rv=%b want 0 0 35 0",
                           i, set_find, set_add, set_x, resp_valid);
      end
    end
    set_rdy = 1'b1; set_found = 1'b0;
    tick();
    n_checks++;
    if ({resp_valid, resp_op, resp_data, resp_found, resp_timeout} !== {1'b1, 1'b0, 8'h35, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL find_resp: got v=%b op=%b d=%h f=%b t=%b want 1 0 35 0 0",
                         resp_valid, resp_op, resp_data, resp_found, resp_timeout);
    end
    tick();
    n_checks++;
    if ({hit_cnt, miss_cnt, tmo_cnt} !== {16'd1, 16'd1, 16'd0}) begin
      n_fail++; $display("FAIL find_counters: got %0d/%0d/%0d want 1/1/0", hit_cnt, miss_cnt, tmo_cnt);
    end
  endtask

  task automatic test_back_to_back;
    logic [DATA_W-1:0] keys [5];
    logic              ops  [5];
    logic              strobe_seen;
    int                n;
    keys = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    ops  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    set_rdy = 1'b0; set_found = 1'b1;
    strobe_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1; cmd_op = ops[i]; cmd_data = keys[i];
      tick();
      strobe_seen |= set_find | set_add;
      n_checks++;
      if (cmd_ready !== (i < 3)) begin
        n_fail++; $display("FAIL fill_ready_%0d: got %b want %b", i, cmd_ready, (i < 3));
      end
    end
    cmd_valid = 1'b0;
    n_checks++;
    if (strobe_seen !== 1'b0) begin
      n_fail++; $display("FAIL fill_no_strobe: got strobe=%b want 0", strobe_seen);
    end
    set_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_strobe(n);
      n_checks++;
      if (n >= LIMIT || {set_find, set_add, set_x} !== {!ops[i], ops[i], keys[i]}) begin
        n_fail++; $display("FAIL drain_issue_%0d: got find=%b add=%b x=%h want %b %b %h",
                           i, set_find, set_add, set_x, !ops[i], ops[i], keys[i]);
      end
      wait_resp(n);
      n_checks++;
      if (n >= LIMIT || {resp_op, resp_data, resp_found, resp_timeout} !== {ops[i], keys[i], 1'b1, 1'b0}) begin
        n_fail++; $display("FAIL drain_resp_%0d: got op=%b d=%h f=%b t=%b want %b %h 1 0",
                           i, resp_op, resp_data, resp_found, resp_timeout, ops[i], keys[i]);
      end
    end
    tick(); tick(); tick();
    n_checks++;
    if ({busy, hit_cnt} !== {1'b0, 16'd5}) begin
      n_fail++; $display("FAIL drain_done: got busy=%b hit=%0d want 0 5", busy, hit_cnt);
    end
  endtask

  task automatic test_timeout;
    logic strobe_seen;
    int   n;
    set_rdy = 1'b1; set_found = 1'b1;
    push(1'b0, 8'h66);
    wait_strobe(n);
    set_rdy = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!resp_valid && n < 40);
    n_checks++;
    if (n != TIMEOUT + 1) begin
      n_fail++; $display("FAIL tmo_latency: got %0d cycles after issue want %0d", n, TIMEOUT + 1);
    end
    n_checks++;
    if ({resp_op, resp_data, resp_found, resp_timeout} !== {1'b0, 8'h66, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL tmo_resp: got op=%b d=%h f=%b t=%b want 0 66 0 1",
                         resp_op, resp_data, resp_found, resp_timeout);
    end
    tick();
    n_checks++;
    if ({hit_cnt, miss_cnt, tmo_cnt} !== {16'd5, 16'd1, 16'd1}) begin
      n_fail++; $display("FAIL tmo_counters: got %0d/%0d/%0d want 5/1/1", hit_cnt, miss_cnt, tmo_cnt);
    end
    // With the set still not ready, a queued command must wait.
    push(1'b0, 8'h77);
    strobe_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      strobe_seen |= set_find | set_add;
    end
    n_checks++;
    if ({strobe_seen, busy} !== 2'b01) begin
      n_fail++; $display("FAIL tmo_hold_issue: got strobe=%b busy=%b want 0 1", strobe_seen, busy);
    end
    set_rdy = 1'b1;
    wait_strobe(n);
    n_checks++;
    if (n != 1 || {set_find, set_x} !== {1'b1, 8'h77}) begin
      n_fail++; $display("FAIL tmo_next_issue: got n=%0d find=%b x=%h want 1 1 77", n, set_find, set_x);
    end
    wait_resp(n);
    tick();
    n_checks++;
    if (hit_cnt !== 16'd6) begin
      n_fail++; $display("FAIL tmo_next_hit: got %0d want 6", hit_cnt);
    end
  endtask

  task automatic test_resp_backpressure;
    int n;
    resp_ready = 1'b0; set_rdy = 1'b1; set_found = 1'b0;
    push(1'b1, 8'h88);
    push(1'b0, 8'h99);  // same edge as the pop of 0x88
    wait_resp(n);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if ({resp_valid, resp_op, resp_data, resp_found, resp_timeout, set_find, set_add, miss_cnt} !==
          {1'b1, 1'b1, 8'h88, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1}) begin
        n_fail++; $display("FAIL hold_%0d: got v=%b op=%b d=%h f=%b t=%b strobes=%b%b miss=%0d want 1 1 88 0 0 00 1",
                           i, resp_valid, resp_op, resp_data, resp_found, resp_timeout,
                           set_find, set_add, miss_cnt);
      end
      tick();
    end
    resp_ready = 1'b1;
    tick();
    n_checks++;
    if ({resp_valid, miss_cnt} !== {1'b0, 16'd2}) begin
      n_fail++; $display("FAIL hold_release: got rv=%b miss=%0d want 0 2", resp_valid, miss_cnt);
    end
    wait_strobe(n);
    n_checks++;
    if (n >= LIMIT || {set_find, set_x} !== {1'b1, 8'h99}) begin
      n_fail++; $display("FAIL hold_next_issue: got find=%b x=%h want 1 99", set_find, set_x);
    end
    wait_resp(n);
    tick();
    n_checks++;
    if (miss_cnt !== 16'd3) begin
      n_fail++; $display("FAIL hold_next_miss: got %0d want 3", miss_cnt);
    end
  endtask

  task automatic test_reset_midop;
    int events;
    int n;
    set_rdy = 1'b1; set_found = 1'b1;
    push(1'b1, 8'hA1);
    wait_strobe(n);
    set_rdy = 1'b0;
    push(1'b0, 8'hB2);
    push(1'b1, 8'hC3);
    n_checks++;
    if ({busy, resp_valid} !== 2'b10) begin
      n_fail++; $display("FAIL mid_busy: got busy=%b rv=%b want 1 0", busy, resp_valid);
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if ({set_find, set_add, set_x, resp_valid, resp_op, resp_data, resp_found, resp_timeout,
         busy, hit_cnt, miss_cnt, tmo_cnt, !cmd_ready} !== '0) begin
      n_fail++; $display("FAIL mid_reset: got x=%h rv=%b busy=%b ready=%b cnt=%h/%h/%h want zeros, ready 1",
                         set_x, resp_valid, busy, cmd_ready, hit_cnt, miss_cnt, tmo_cnt);
    end
    reset = 1'b0; set_rdy = 1'b1;
    events = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (set_find || set_add || resp_valid || busy) events++;
    end
    n_checks++;
    if (events != 0) begin
      n_fail++; $display("FAIL mid_no_response: got %0d activity cycles want 0", events);
    end
  endtask

  initial begin
    test_reset();
    test_add_single();
    test_find_probes();
    test_back_to_back();
    test_timeout();
    test_resp_backpressure();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/set_cmd_sequencer.md
Name: set_cmd_sequencer

Overview:
- Command front-end placed directly upstream of the hash-set block (find/add/x → rdy/found).
- Buffers find/add requests from a valid/ready stream and issues them to the set one at a time, holding x stable for the whole probe.
- Captures the found result and returns it on a valid/ready response stream, together with hit/miss/timeout statistics.

Parameters:
- DATA_W, 8, width of key x; must match the set.
- FIFO_DEPTH, 4, command FIFO entries; power of two, ≥2.
- TIMEOUT, 20, max WAIT cycles before an op is aborted; must be > 17 (16 probes + issue).
- CNT_W, 16, width of statistics counters.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept.
- cmd_op  in  1  0=find, 1=add.
- cmd_data  in  DATA_W  key.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts.
- resp_op  out  1  op of completed command.
- resp_data  out  DATA_W  key of completed command.
- resp_found  out  1  find: key present; add: key inserted.
- resp_timeout  out  1  op aborted by watchdog.
- set_find  out  1  one-cycle start pulse to set.
- set_add  out  1  one-cycle start pulse to set.
- set_x  out  DATA_W  key to set; stable from ISSUE through end of WAIT.
- set_rdy  in  1  set idle.
- set_found  in  1  set result flag.
- busy  out  1  FSM not in IDLE or FIFO non-empty.
- hit_cnt  out  CNT_W  completions with resp_found=1.
- miss_cnt  out  CNT_W  completions with resp_found=0 and no timeout.
- tmo_cnt  out  CNT_W  timeouts.

Behaviour:
- Reset (synchronous, active-high): FIFO emptied; state=IDLE; every output 0 (set_find, set_add, set_x, resp_*, counters, busy); cmd_ready=1 on the first cycle after reset deasserts.
- Reset mid-operation: abort any in-flight op; no response is produced. The set is reset by the same reset net.
- FIFO: cmd_ready = !full. Push on cmd_valid && cmd_ready. Pop only in IDLE→ISSUE. Push and pop in the same cycle are allowed. Pointers wrap modulo FIFO_DEPTH. Occupancy counter is FIFO_DEPTH+1 values wide.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: when FIFO non-empty && set_rdy, pop the head into the op/data registers and go to ISSUE. Otherwise stay.
- ISSUE (1 cycle):
  - set_find=!op and set_add=op; exactly one is asserted, for exactly one cycle.
  - set_x = data register.
  - Watchdog counter cleared; go to WAIT.
- WAIT:
  - set_find=set_add=0; set_x held.
  - Each cycle, increment the watchdog.
  - If set_rdy==1, latch resp_found=set_found and resp_timeout=0, then go to RESP. This case includes the first WAIT cycle, for ops the set completes in one cycle.
  - Else if the watchdog reaches TIMEOUT, latch resp_found=0 and resp_timeout=1, then go to RESP.
- RESP:
  - resp_valid=1; resp_op and resp_data come from the registers.
  - All resp_* are held stable until resp_ready.
  - On resp_valid && resp_ready, update counters and go to IDLE. No back-to-back issue from RESP: minimum 4 cycles per command.
- Counters increment by 1 on response handshake and saturate at all-ones; no wrap.
- set_find/set_add are never asserted while set_rdy==0.
- busy = (state!=IDLE) || !empty.

Decomposition:
- Shared package set_pkg holds:
  - DATA_W default.
  - Enum op_e {OP_FIND=0, OP_ADD=1}.
  - State enum seq_state_e {IDLE, ISSUE, WAIT, RESP}.
  - Constant SET_MAX_PROBE=16.
- One sub-module: cmd_fifo (parameterised synchronous FIFO, width DATA_W+1, depth FIFO_DEPTH, with full/empty outputs).
- FSM, watchdog and counters live in the top-level module.

Test Plan:
- Reset, then add 0x25 with set_rdy held 1 and set_found=1 in the issue cycle → set_add pulse exactly 1 cycle, set_x=0x25, resp {op=1, data=0x25, found=1, timeout=0}, hit_cnt=1.
- Find 0x35, set model takes 3 probes (set_rdy low 2 cycles, then high with set_found=0) → set_x=0x35 throughout, resp found=0, miss_cnt=1.
- Push 5 commands back-to-back with set_rdy=0 and FIFO_DEPTH=4 → cmd_ready=0 after the 4th push; no set_find/set_add asserted; raising set_rdy drains all in order, each response matching its key.
- Hold set_rdy=0 after ISSUE → resp_timeout=1 and found=0 after 20 WAIT cycles; tmo_cnt=1; next command issues normally.
- resp_ready=0 for 10 cycles → resp_* stable, no new set_find/set_add, counters unchanged until the handshake.
- Assert reset in WAIT with 2 commands queued → next cycle: outputs 0, FIFO empty, no response ever produced for the aborted or queued commands.
